// File: rtl/icache_refill.sv
// icache_refill: fetches one aligned cache line as a single incrementing read burst
module icache_refill #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int BEATS  = 8,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pa,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_len,
    input  logic              rd_addr_ok,
    input  logic              ret_valid,
    input  logic              ret_last,
    input  logic [WORD_W-1:0] ret_data,
    output logic              line_valid,
    output logic              line_err,
    output logic [LINE_W-1:0] r_data,
    output logic              busy
);
    localparam int CW = $clog2(BEATS);
    localparam int OFF = $clog2(LINE_W / 8);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
    typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic unused_off;
    assign unused_off = ^req_pa[OFF-1:0];
    assign rd_len = 8'(BEATS - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            rd_req     <= 1'b0;
            rd_addr    <= '0;
            line_valid <= 1'b0;
            line_err   <= 1'b0;
            r_data     <= '0;
            busy       <= 1'b0;
        end else begin
            line_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    rd_addr   <= {req_pa[ADDR_W-1:OFF], OFF'(0)};
                    cnt       <= '0;
                    line_err  <= 1'b0;
                    rd_req    <= 1'b1;
                    req_ready <= 1'b0;
                    busy      <= 1'b1;
                    state     <= REQ;
                end
                REQ: if (rd_addr_ok) begin
                    rd_req <= 1'b0;
                    state  <= RECV;
                end
                RECV: if (ret_valid) begin
                    r_data[int'(cnt)*WORD_W +: WORD_W] <= ret_data;
                    cnt <= cnt + CW'(1);
                    if (ret_last || cnt == LAST) begin
                        line_valid <= 1'b1;
                        line_err   <= ret_last != (cnt == LAST);
                        state      <= DONE;
                    end
                end
                DONE: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
